rv32i_fetch_stage: RTL

//  Instruction-fetch stage directly upstream of the dual-port instruction ROM (port A).
//  - Holds the PC and drives the ROM word address.
//  - Absorbs the ROM's 1-cycle registered-read latency.
//  - Delivers {pc, instr} to decode over a valid/ready handshake, buffered in a 2-entry skid FIFO.
//  - Accepts redirects (branch/jump/trap) from execute and discards wrong-path fetches.

---
 rtl/rv32i_fetch_stage_if.sv | 28 ++
 rtl/rv32i_fetch_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_stage_if.sv
// Decode-side handshake of the instruction-fetch stage.
//   out_valid  fetch -> decode  an {pc, instr} pair is presented
//   out_ready  decode -> fetch  decode accepts when out_valid & out_ready
//   out_pc     fetch -> decode  byte PC of the presented instruction
//   out_instr  fetch -> decode  presented instruction word
// The fetch stage connects through the master modport, decode through the slave modport.
interface rv32i_fetch_stage_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [DWIDTH-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );
endinterface

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage sitting directly in front of port A of the instruction ROM.
// Holds the PC, drives the ROM word address, absorbs the ROM's one-cycle registered read and
// hands {pc, instr} pairs to decode through a 2-entry skid FIFO with a bypass path, so a word
// issued in cycle c is presented in cycle c+1 and a steady stream runs at one word per cycle.
// Redirects from execute flush all buffered and in-flight wrong-path words.
//
// Ports
//   clock           single clock, shared with ROM port A
//   reset_n         asynchronous active-low reset
//   fetch_en        1 = new ROM reads may be issued
//   rom_addr        ROM port-A word address (combinational from the fetch address)
//   rom_q           ROM port-A read data, valid the cycle after an issue
//   redirect_valid  1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     new byte PC (low two bits are dropped)
//   misalign_err    1 in a redirect cycle whose redirect_pc[1:0] != 0
//   dec             decode handshake (out_valid/out_ready/out_pc/out_instr)
module rv32i_fetch_stage #(
  parameter int unsigned AWIDTH   = 13,
  parameter int unsigned DWIDTH   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      fetch_en,
  output logic [AWIDTH-1:0]         rom_addr,
  input  logic [DWIDTH-1:0]         rom_q,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      misalign_err,
  rv32i_fetch_stage_if.master       dec
);

  // Architectural fetch state.
  logic [31:0]       pc_q;
  logic [31:0]       req_pc_q;    // PC of the word whose ROM read is in flight
  logic              inflight_q;

  // Skid FIFO, two entries.
  logic [1:0]        count_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [31:0]       fifo_pc_q    [2];
  logic [DWIDTH-1:0] fifo_instr_q [2];

  // Next-state and control.
  logic              redir;
  logic [31:0]       fa;
  logic              fifo_empty;
  logic              pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2:0]        occ_next;
  logic              issue;
  logic [1:0]        count_d;

  always_comb begin
    // Redirect is masked during reset so rom_addr shows RESET_PC and no error pulse escapes.
    redir = redirect_valid & reset_n;
    fa    = redir ? {redirect_pc[31:2], 2'b00} : pc_q;

    // Upper PC bits are simply dropped, so the ROM address wraps.
    rom_addr     = fa[AWIDTH+1:2];
    misalign_err = redir & (redirect_pc[1:0] != 2'b00);

    fifo_empty = (count_q == 2'd0);

    // With an empty FIFO the ROM response is presented directly (bypass); otherwise the head
    // of the FIFO is shown and the response goes to the tail.
    dec.out_valid = ~redir & (inflight_q | ~fifo_empty);
    dec.out_pc    = fifo_empty ? req_pc_q : fifo_pc_q[rd_ptr_q];
    dec.out_instr = fifo_empty ? rom_q    : fifo_instr_q[rd_ptr_q];

    pop       = dec.out_valid & dec.out_ready;
    fifo_pop  = pop & ~fifo_empty;
    // The in-flight response is stored unless it leaves immediately via the bypass.
    fifo_push = inflight_q & ~(pop & fifo_empty);

    // Words held after this edge, not counting a new issue. pop implies at least one word
    // exists, so this never underflows.
    occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Issue only if the returning word will have a slot: buffered + inflight <= 2 always.
    issue   = fetch_en & (redir | (occ_next < 3'd2));
    count_d = redir ? 2'd0 : occ_next[1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      if (issue) begin
        pc_q     <= fa + 32'd4;
        req_pc_q <= fa;
      end else if (redir) begin
        pc_q     <= fa;
      end
      // A redirect without an issue also clears this, dropping the wrong-path response.
      inflight_q <= issue;
      count_q    <= count_d;
      if (redir) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
        if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // FIFO storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clock) begin
    if (!redir && fifo_push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= rom_q;
    end
  end

endmodule
